xfer2ringbuf_seq: RTL
=====================

Name: xfer2ringbuf_seq

Overview:
Parametrised successor to the DAQ FIFO-to-ring-buffer transfer path. It has an integrated sequencer; the FSM is not external. On each RDY it drains NSAMP samples from each of NCHAN channel FIFOs in ascending channel order and writes them to the ring buffer as one fixed-size frame. It adds a per-channel mask and empty-FIFO underflow protection with an error counter. It sits between the per-channel sample FIFOs and the L1A ring buffer.

Parameters:
NCHAN, 16, number of channel FIFOs (2..32)
DW, 12, sample width in bits
NSAMP, 8, samples read per channel per frame (1..255)
CHW, 4, channel index width, equal to clog2(NCHAN)
FILL, all-ones of DW, word substituted for a masked or underflowed sample

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
JTAG_MODE  in  1  JTAG override of FIFO reads
J_RD_FIFO  in  1  JTAG read strobe, broadcast to all FIFOs
DIN  in  NCHAN*DW  FWFT FIFO outputs; channel k occupies bits [k*DW+DW-1 : k*DW]
RDY  in  1  event ready; frame requested
F_MT  in  NCHAN  per-channel FIFO empty flags
CHAN_MASK  in  NCHAN  1 = channel disabled (never read, FILL written)
RD_ENA  out  NCHAN  registered one-hot FIFO read enables
L1A_RD_EN  out  1  one-cycle pulse at frame start
WREN  out  1  ring-buffer write enable
DMUX  out  DW  ring-buffer write data
CHAN_OUT  out  CHW  channel of the current DMUX word
BUSY  out  1  frame in progress
DONE  out  1  one-cycle pulse, coincident with the last WREN of a frame
UNDERFLOW  out  1  sticky; set by any underflow in the current frame
ERRCNT  out  16  saturating count of underflowed samples since reset

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. RST takes priority over everything and may occur mid-frame. The partial frame is dropped and no DONE is issued.
- FSM states: IDLE, START, XFER, DRAIN, FIN.
  - IDLE: if RDY=1 and JTAG_MODE=0, go to START.
  - START: L1A_RD_EN=1 for exactly this cycle. Clear UNDERFLOW, ch=0, smp=0. Go to XFER.
  - XFER: issue one slot per cycle for (ch, smp). smp increments; at NSAMP-1 it wraps to 0 and ch increments. After the slot (NCHAN-1, NSAMP-1), go to DRAIN.
  - DRAIN: 2 cycles to empty the pipeline, then go to FIN.
  - FIN: 1 cycle, then go to IDLE. RDY is only sampled in IDLE, so there is at least 1 idle cycle between frames.
- Slot issue in cycle t, one of three cases:
  - Normal: mask=0 and F_MT[ch]=0. Real read: RD_ENA[ch]=1 in t+1.
  - Masked: mask=1. No read. FILL is written.
  - Underflow: mask=0 and F_MT[ch]=1. No read. FILL is written, UNDERFLOW is set, ERRCNT increments (saturating at 0xFFFF).
- Pipeline timing:
  - RD_ENA is registered, at t+1. At most one bit is high outside JTAG mode.
  - WREN, DMUX and CHAN_OUT are registered, at t+2.
  - DMUX takes DIN[ch] as presented during t+1 (FWFT: data is valid while its RD_ENA is high), or FILL for non-read slots.
- Every slot produces exactly one WREN, so each frame is exactly NCHAN*NSAMP consecutive WREN cycles.
- BUSY is 1 from START through FIN inclusive. DONE pulses on the final WREN cycle.
- CHAN_MASK and F_MT are sampled per slot. A mask change mid-frame takes effect at the next slot.
- JTAG_MODE=1:
  - RD_ENA becomes {NCHAN{J_RD_FIFO}}, registered, 1-cycle latency.
  - WREN is forced to 0 and L1A_RD_EN to 0.
  - If asserted mid-frame, the FSM aborts to IDLE: no DONE, BUSY drops the next cycle, and in-flight WRENs are suppressed.
- Width rules: the smp counter is 8 bits. The channel counter is CHW bits with a terminal compare against NCHAN-1, so non-power-of-2 NCHAN is supported.

Test Plan:
- Basic frame: NCHAN=16, NSAMP=8, no mask, FIFOs preloaded with k*16+s. Pulse RDY → L1A_RD_EN 1 cycle; 128 WRENs back-to-back; first WREN 3 cycles after START; DMUX sequence 0x000..0x0F7 in order; DONE on WREN #128; UNDERFLOW=0.
- Mask: CHAN_MASK=0x0102 → channels 1 and 8 never see RD_ENA; their 8 slots each write 0xFFF; frame is still 128 words.
- Underflow: channel 5 holds only 3 words → slots 5.3..5.7 write 0xFFF; UNDERFLOW=1; ERRCNT=5; the next clean frame clears UNDERFLOW and leaves ERRCNT=5.
- JTAG: JTAG_MODE=1 with J_RD_FIFO toggling → RD_ENA=0xFFFF one cycle after each high; WREN=0. Asserting JTAG_MODE at WREN #40 → aborts; no DONE; BUSY=0 next cycle.
- Reset mid-frame: RST at slot 60 → next cycle all outputs 0. RDY then yields a full clean 128-word frame.
- Non-power-of-2: NCHAN=6, CHW=3, NSAMP=1 → exactly 6 WRENs, CHAN_OUT 0..5, DONE on the 6th. RDY held high → frames separated by at least 1 idle cycle.

Source files
------------

// File: rtl/xfer2ringbuf_seq.sv
// xfer2ringbuf_seq: sequenced transfer of per-channel FWFT FIFO samples into
// the L1A ring buffer. Each RDY frame drains NSAMP samples per channel, in
// ascending channel order, as NCHAN*NSAMP consecutive ring-buffer writes.
// Masked channels and empty FIFOs write FILL instead of a real sample.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   JTAG_MODE, J_RD_FIFO  JTAG override: broadcast read strobe, write gating
//   DIN, F_MT, CHAN_MASK  FIFO data (channel k at [k*DW +: DW]), empties, mask
//   RDY                   frame request, sampled only when idle
//   RD_ENA                one-hot FIFO read enables
//   L1A_RD_EN             pulse in the frame's start cycle
//   WREN, DMUX, CHAN_OUT  ring-buffer write strobe, data, source channel
//   BUSY, DONE            frame in progress, last-write pulse
//   UNDERFLOW, ERRCNT     per-frame underflow flag, saturating underflow count
module xfer2ringbuf_seq #(
  parameter int unsigned   NCHAN = 16,
  parameter int unsigned   DW    = 12,
  parameter int unsigned   NSAMP = 8,
  parameter int unsigned   CHW   = 4,
  parameter logic [DW-1:0] FILL  = {DW{1'b1}}
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                JTAG_MODE,
  input  logic                J_RD_FIFO,
  input  logic [NCHAN*DW-1:0] DIN,
  input  logic                RDY,
  input  logic [NCHAN-1:0]    F_MT,
  input  logic [NCHAN-1:0]    CHAN_MASK,
  output logic [NCHAN-1:0]    RD_ENA,
  output logic                L1A_RD_EN,
  output logic                WREN,
  output logic [DW-1:0]       DMUX,
  output logic [CHW-1:0]      CHAN_OUT,
  output logic                BUSY,
  output logic                DONE,
  output logic                UNDERFLOW,
  output logic [15:0]         ERRCNT
);

  localparam int unsigned    SW       = 8;
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NCHAN - 1);
  localparam logic [SW-1:0]  LAST_SMP = SW'(NSAMP - 1);

  typedef enum logic [2:0] {IDLE, START, XFER, DRAIN, FIN} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q;
  logic [SW-1:0]  smp_q;
  logic           drain_q;

  logic slot_c, last_slot_c, masked_c, empty_c, rd_c, uflow_c;

  // Slot pipeline stage between issue (t) and write (t+2)
  logic           s1_vld_q, s1_fill_q, s1_last_q;
  logic [CHW-1:0] s1_ch_q;

  logic [NCHAN-1:0][DW-1:0] din_a;
  assign din_a = DIN;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and slot classification
  always_comb begin
    state_d     = state_q;
    slot_c      = 1'b0;
    last_slot_c = 1'b0;
    masked_c    = 1'b0;
    empty_c     = 1'b0;
    rd_c        = 1'b0;
    uflow_c     = 1'b0;
    case (state_q)
      IDLE:  if (RDY) state_d = START;
      START: state_d = XFER;
      XFER: begin
        slot_c      = 1'b1;
        last_slot_c = (ch_q == LAST_CH) && (smp_q == LAST_SMP);
        if (last_slot_c) state_d = DRAIN;
      end
      DRAIN: if (drain_q) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // JTAG ownership of the FIFOs aborts any frame and blocks new ones
    if (JTAG_MODE) begin
      state_d     = IDLE;
      slot_c      = 1'b0;
      last_slot_c = 1'b0;
    end
    masked_c = CHAN_MASK[ch_q];
    empty_c  = F_MT[ch_q];
    rd_c     = slot_c && !masked_c && !empty_c;
    uflow_c  = slot_c && !masked_c && empty_c;
  end

  // Channel/sample counters and drain timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_q    <= '0;
      smp_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      drain_q <= (state_q == DRAIN) && !drain_q;
      if (state_q == START) begin
        ch_q  <= '0;
        smp_q <= '0;
      end else if (slot_c && !last_slot_c) begin
        // Held on the final slot so ch_q never leaves 0..NCHAN-1
        if (smp_q == LAST_SMP) begin
          smp_q <= '0;
          ch_q  <= ch_q + CHW'(1);
        end else begin
          smp_q <= smp_q + SW'(1);
        end
      end
    end
  end

  // Read enables, write pipeline and status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld_q  <= 1'b0;
      s1_fill_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_ch_q   <= '0;
      RD_ENA    <= '0;
      L1A_RD_EN <= 1'b0;
      WREN      <= 1'b0;
      DMUX      <= '0;
      CHAN_OUT  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      UNDERFLOW <= 1'b0;
      ERRCNT    <= '0;
    end else begin
      s1_vld_q  <= slot_c;
      s1_last_q <= last_slot_c;
      s1_fill_q <= !rd_c;
      s1_ch_q   <= ch_q;
      if (JTAG_MODE)  RD_ENA <= {NCHAN{J_RD_FIFO}};
      else if (rd_c)  RD_ENA <= NCHAN'(1) << ch_q;
      else            RD_ENA <= '0;
      // JTAG also squashes writes already in the pipeline
      WREN <= s1_vld_q && !JTAG_MODE;
      DONE <= s1_last_q && !JTAG_MODE;
      // FWFT: the sample is on DIN during the cycle its read enable is high
      if (s1_vld_q) begin
        DMUX     <= s1_fill_q ? FILL : din_a[s1_ch_q];
        CHAN_OUT <= s1_ch_q;
      end
      L1A_RD_EN <= (state_d == START);
      BUSY      <= (state_d != IDLE);
      if (state_q == START) UNDERFLOW <= 1'b0;
      else if (uflow_c)     UNDERFLOW <= 1'b1;
      if (uflow_c && (ERRCNT != 16'hFFFF)) ERRCNT <= ERRCNT + 16'd1;
    end
  end

endmodule
